// File: rtl/chan_packet_reader.sv
// Read-side consumer of the per-channel packet ring: parses header and timestamp,
// holds the packet until its send time, then streams I/Q payload words to the DAC path.
module chan_packet_reader #(
   parameter logic [31:0] NO_TIMESTAMP      = 32'hFFFF_FFFF,
   parameter int          MAX_PAYLOAD_WORDS = 126
) (
   input  logic        txclk,
   input  logic        reset,
   input  logic [31:0] fifodata,
   input  logic        pkt_waiting,
   output logic        rd,
   output logic        rd_done,
   input  logic [31:0] adc_time,
   input  logic        tx_strobe,
   output logic [15:0] tx_i,
   output logic [15:0] tx_q,
   output logic        bursting,
   output logic        late,
   output logic        underrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_TS,
      S_WAIT,
      S_SEND,
      S_DROP,
      S_DONE
   } state_t;

   typedef struct packed {
      logic       sob;
      logic       eob;
      logic [6:0] words;
   } hdr_t;

   state_t      state_q, state_d;
   hdr_t        hdr_q, hdr_d;
   logic [31:0] ts_q, ts_d;
   logic [15:0] tx_i_q, tx_i_d;
   logic [15:0] tx_q_q, tx_q_d;
   logic        bursting_q, bursting_d;

   logic [9:0]  len_round;
   logic [7:0]  words_raw;
   logic [6:0]  words_clamped;
   logic [31:0] ts_delta;

   // Round bytes up to words in 10 bits so len=511 cannot wrap before the clamp.
   assign len_round     = {1'b0, fifodata[8:0]} + 10'd3;
   assign words_raw     = len_round[9:2];
   assign words_clamped = (words_raw > 8'(MAX_PAYLOAD_WORDS)) ? 7'(MAX_PAYLOAD_WORDS)
                                                              : words_raw[6:0];

   // Modulo-2^32 distance to the send time; bit 31 set means the time is already past.
   assign ts_delta = ts_q - adc_time;

   always_comb begin
      state_d    = state_q;
      hdr_d      = hdr_q;
      ts_d       = ts_q;
      tx_i_d     = tx_i_q;
      tx_q_d     = tx_q_q;
      bursting_d = bursting_q;
      rd         = 1'b0;
      rd_done    = 1'b0;
      late       = 1'b0;
      underrun   = 1'b0;

      if (tx_strobe && (state_q != S_SEND)) begin
         tx_i_d   = 16'd0;
         tx_q_d   = 16'd0;
         underrun = bursting_q;
      end

      case (state_q)
         S_IDLE: begin
            if (pkt_waiting) state_d = S_HDR;
         end
         S_HDR: begin
            rd          = 1'b1;
            hdr_d.sob   = fifodata[28];
            hdr_d.eob   = fifodata[27];
            hdr_d.words = words_clamped;
            state_d     = S_TS;
         end
         S_TS: begin
            rd      = 1'b1;
            ts_d    = fifodata;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (hdr_q.words == 7'd0) begin
               if (hdr_q.sob) bursting_d = 1'b1;
               state_d = S_DONE;
            end else if ((ts_q == NO_TIMESTAMP) || (adc_time == ts_q)) begin
               if (hdr_q.sob) bursting_d = 1'b1;
               state_d = S_SEND;
            end else if (ts_delta[31]) begin
               late    = 1'b1;
               state_d = S_DROP;
            end
         end
         S_SEND: begin
            if (tx_strobe) begin
               tx_i_d      = fifodata[15:0];
               tx_q_d      = fifodata[31:16];
               rd          = 1'b1;
               hdr_d.words = hdr_q.words - 7'd1;
               if (hdr_q.words == 7'd1) state_d = S_DONE;
            end
         end
         // Unread payload is abandoned; rd_done resets the buffer read address anyway.
         S_DROP: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            rd_done = 1'b1;
            if (hdr_q.eob) bursting_d = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge txclk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         hdr_q      <= '0;
         ts_q       <= '0;
         tx_i_q     <= '0;
         tx_q_q     <= '0;
         bursting_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_q      <= hdr_d;
         ts_q       <= ts_d;
         tx_i_q     <= tx_i_d;
         tx_q_q     <= tx_q_d;
         bursting_q <= bursting_d;
      end
   end

   assign tx_i     = tx_i_q;
   assign tx_q     = tx_q_q;
   assign bursting = bursting_q;

endmodule

// File: tb/tb_chan_packet_reader.sv
// Directed bench for chan_packet_reader: a behavioural packet slot feeds fifodata,
// and each step checks hand-computed outputs and rd/rd_done/late/underrun counts.
module tb_chan_packet_reader;

   logic        txclk = 1'b0;
   logic        reset;
   logic [31:0] fifodata;
   logic        pkt_waiting;
   logic        rd;
   logic        rd_done;
   logic [31:0] adc_time = 32'h0000_1000;
   logic        tx_strobe;
   logic [15:0] tx_i;
   logic [15:0] tx_q;
   logic        bursting;
   logic        late;
   logic        underrun;

   logic [31:0] mem [0:127];
   logic [6:0]  addr = 7'd0;
   logic        adc_stall;
   logic [31:0] ts;

   int checks = 0, errors = 0;
   int rd_cnt = 0, done_cnt = 0, late_cnt = 0, un_cnt = 0, both_cnt = 0;
   int r0, d0, l0, u0;

   chan_packet_reader dut (
      .txclk      (txclk),
      .reset      (reset),
      .fifodata   (fifodata),
      .pkt_waiting(pkt_waiting),
      .rd         (rd),
      .rd_done    (rd_done),
      .adc_time   (adc_time),
      .tx_strobe  (tx_strobe),
      .tx_i       (tx_i),
      .tx_q       (tx_q),
      .bursting   (bursting),
      .late       (late),
      .underrun   (underrun)
   );

   always #5 txclk = ~txclk;

   // Show-ahead slot model plus event counters
   assign fifodata = mem[addr];

   always @(posedge txclk) begin
      if (reset || rd_done) addr <= 7'd0;
      else if (rd)          addr <= addr + 7'd1;
      if (!adc_stall) adc_time <= adc_time + 32'd1;
      if (!reset) begin
         if (rd)            rd_cnt   <= rd_cnt + 1;
         if (rd_done)       done_cnt <= done_cnt + 1;
         if (late)          late_cnt <= late_cnt + 1;
         if (underrun)      un_cnt   <= un_cnt + 1;
         if (rd && rd_done) both_cnt <= both_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Leaves the bench on the negedge of the DONE cycle, with pkt_waiting dropped.
   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (rd_done !== 1'b1 && n < budget) begin
         @(negedge txclk);
         n++;
      end
      checks++;
      assert (rd_done === 1'b1) else begin
         errors++;
         $error("FAIL %s rd_done timeout observed=%b expected=1", tag, rd_done);
      end
      pkt_waiting = 1'b0;
   endtask

   task automatic snap();
      r0 = rd_cnt;
      d0 = done_cnt;
      l0 = late_cnt;
      u0 = un_cnt;
   endtask

   initial begin
      reset       = 1'b1;
      pkt_waiting = 1'b0;
      tx_strobe   = 1'b0;
      adc_stall   = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = 32'd0;
      repeat (3) @(negedge txclk);
      check("reset_tx", {tx_q, tx_i}, 32'd0);
      check("reset_ctl", {27'd0, rd, rd_done, bursting, late, underrun}, 32'd0);
      reset = 1'b0;

      // 1: immediate send, two payload words, strobe every cycle
      mem[0] = 32'h0000_0008;
      mem[1] = 32'hFFFF_FFFF;
      mem[2] = 32'h0002_0001;
      mem[3] = 32'h0004_0003;
      snap();
      tx_strobe   = 1'b1;
      pkt_waiting = 1'b1;
      repeat (5) @(posedge txclk);
      @(negedge txclk);
      check("t1_s0", {tx_q, tx_i}, 32'h0002_0001);
      @(negedge txclk);
      check("t1_s1", {tx_q, tx_i}, 32'h0004_0003);
      check("t1_done", {31'd0, rd_done}, 32'd1);
      pkt_waiting = 1'b0;
      @(negedge txclk);
      check("t1_rd", 32'(rd_cnt - r0), 32'd4);
      check("t1_rdd", 32'(done_cnt - d0), 32'd1);
      check("t1_idle", {30'd0, rd, rd_done}, 32'd0);

      // 2: future timestamp, held until adc_time matches
      mem[0] = 32'h0000_0004;
      ts     = adc_time + 32'd100;
      mem[1] = ts;
      mem[2] = 32'h0BBB_0AAA;
      snap();
      pkt_waiting = 1'b1;
      for (int n = 0; n < 300 && adc_time != ts; n++) @(negedge txclk);
      check("t2_match", adc_time, ts);
      check("t2_hold", 32'(rd_cnt - r0), 32'd2);
      wait_done("t2_done", 20);
      check("t2_tx", {tx_q, tx_i}, 32'h0BBB_0AAA);
      check("t2_late", 32'(late_cnt - l0), 32'd0);
      check("t2_rd", 32'(rd_cnt - r0), 32'd3);
      @(negedge txclk);

      // 3: timestamp already past -> dropped
      mem[0] = 32'h0000_0004;
      mem[1] = adc_time - 32'd5;
      mem[2] = 32'h0DDD_0CCC;
      snap();
      pkt_waiting = 1'b1;
      wait_done("t3_done", 20);
      @(negedge txclk);
      check("t3_late", 32'(late_cnt - l0), 32'd1);
      check("t3_rd", 32'(rd_cnt - r0), 32'd2);
      check("t3_rdd", 32'(done_cnt - d0), 32'd1);
      check("t3_tx", {tx_q, tx_i}, 32'd0);

      // Stalled time base: exact match sends, 2^31 ahead counts as late
      adc_stall = 1'b1;
      @(negedge txclk);
      mem[0] = 32'h0000_0004;
      mem[1] = adc_time;
      mem[2] = 32'h000A_0009;
      snap();
      pkt_waiting = 1'b1;
      wait_done("ts_eq_done", 20);
      check("ts_eq_tx", {tx_q, tx_i}, 32'h000A_0009);
      check("ts_eq_late", 32'(late_cnt - l0), 32'd0);
      @(negedge txclk);
      mem[1] = adc_time + 32'h8000_0000;
      snap();
      pkt_waiting = 1'b1;
      wait_done("ts_half_done", 20);
      check("ts_half_late", 32'(late_cnt - l0), 32'd1);
      check("ts_half_rd", 32'(rd_cnt - r0), 32'd2);
      @(negedge txclk);
      adc_stall = 1'b0;

      // 4: start-of-burst packet, then starved strobes
      mem[0] = 32'h1000_0004;
      mem[1] = 32'hFFFF_FFFF;
      mem[2] = 32'h0006_0005;
      pkt_waiting = 1'b1;
      wait_done("t4_done", 20);
      check("t4_burst", {31'd0, bursting}, 32'd1);
      check("t4_tx", {tx_q, tx_i}, 32'h0006_0005);
      snap();
      repeat (5) @(posedge txclk);
      @(negedge txclk);
      check("t4_underrun_cnt", 32'(un_cnt - u0), 32'd5);
      check("t4_underrun", {31'd0, underrun}, 32'd1);

      // 5: end-of-burst packet closes the burst
      mem[0] = 32'h0800_0004;
      mem[2] = 32'h0008_0007;
      pkt_waiting = 1'b1;
      wait_done("t5_done", 20);
      check("t5_tx", {tx_q, tx_i}, 32'h0008_0007);
      check("t5_burst_in_done", {31'd0, bursting}, 32'd1);
      @(negedge txclk);
      check("t5_burst_off", {31'd0, bursting}, 32'd0);
      snap();
      repeat (5) @(negedge txclk);
      check("t5_underrun_cnt", 32'(un_cnt - u0), 32'd0);
      check("t5_tx_zero", {tx_q, tx_i}, 32'd0);

      // 6: maximum length clamps to 126 payload words
      mem[0] = 32'h0000_01FF;
      mem[1] = 32'hFFFF_FFFF;
      for (int i = 2; i < 128; i++) mem[i] = {16'(i + 256), 16'(i)};
      snap();
      pkt_waiting = 1'b1;
      wait_done("t6_done", 400);
      check("t6_rd", 32'(rd_cnt - r0), 32'd128);
      check("t6_last", {tx_q, tx_i}, 32'h017F_007F);
      @(negedge txclk);

      // 7: zero-length packet
      mem[0] = 32'h0000_0000;
      snap();
      pkt_waiting = 1'b1;
      wait_done("t7_done", 20);
      @(negedge txclk);
      check("t7_rd", 32'(rd_cnt - r0), 32'd2);
      check("t7_rdd", 32'(done_cnt - d0), 32'd1);

      // 8: reset while holding in SEND
      mem[0] = 32'h1000_0008;
      mem[2] = 32'h0012_0011;
      mem[3] = 32'h0014_0013;
      tx_strobe   = 1'b0;
      pkt_waiting = 1'b1;
      repeat (6) @(negedge txclk);
      check("t8_hold_rd", {31'd0, rd}, 32'd0);
      check("t8_burst", {31'd0, bursting}, 32'd1);
      tx_strobe = 1'b1;
      @(negedge txclk);
      check("t8_tx", {tx_q, tx_i}, 32'h0012_0011);
      tx_strobe   = 1'b0;
      pkt_waiting = 1'b0;
      reset       = 1'b1;
      snap();
      @(negedge txclk);
      check("t8_rst_tx", {tx_q, tx_i}, 32'd0);
      check("t8_rst_ctl", {27'd0, rd, rd_done, bursting, late, underrun}, 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge txclk);
      check("t8_no_rdd", 32'(done_cnt - d0), 32'd0);
      check("t8_idle", {30'd0, rd, rd_done}, 32'd0);

      check("rd_and_rd_done", 32'(both_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
